// File: rtl/mc_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// mc_ctrl_pkg : state encoding, opcodes, ALU-op and PC-select constants
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC   = 4'd3,
    S_MEM    = 4'd4,
    S_WB     = 4'd5,
    S_MEMWB  = 4'd6,
    S_ERR    = 4'd7
  } state_e;

  localparam logic [5:0] c_OP_R     = 6'b000000;
  localparam logic [5:0] c_OP_J     = 6'b000010;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_ADDIU = 6'b001001;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;

  localparam logic [1:0] c_ALU_ADD   = 2'b00;
  localparam logic [1:0] c_ALU_SUB   = 2'b01;
  localparam logic [1:0] c_ALU_FUNCT = 2'b10;

  localparam logic [1:0] c_PCS_SEQ    = 2'd0;
  localparam logic [1:0] c_PCS_JUMP   = 2'd1;
  localparam logic [1:0] c_PCS_BRANCH = 2'd2;

endpackage

`default_nettype wire

// File: rtl/mc_ctrl_fsm_if.sv
// ----------------------------------------------------------------------------
// mc_ctrl_fsm_if : controller <-> datapath/memory signal bundle
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface mc_ctrl_fsm_if #(
  parameter int OPC_W   = 6,
  parameter int ALUOP_W = 2,
  parameter int CNT_W   = 32
);
  logic [OPC_W-1:0]   opcode;
  logic               alu_zero;
  logic               mem_ready;
  logic               pc_ld;
  logic [1:0]         pc_sel;
  logic               iord;
  logic               mem_rd;
  logic               mem_wr;
  logic               ir_wr;
  logic               reg_dst;
  logic               mem_to_reg;
  logic               reg_rd;
  logic               reg_wr;
  logic [1:0]         alu_src_b;
  logic [ALUOP_W-1:0] alu_op;
  logic [CNT_W-1:0]   retired;
  logic               err;
  logic [3:0]         state_o;

  modport master (
    input  opcode, alu_zero, mem_ready,
    output pc_ld, pc_sel, iord, mem_rd, mem_wr, ir_wr, reg_dst, mem_to_reg,
           reg_rd, reg_wr, alu_src_b, alu_op, retired, err, state_o
  );

  modport slave (
    output opcode, alu_zero, mem_ready,
    input  pc_ld, pc_sel, iord, mem_rd, mem_wr, ir_wr, reg_dst, mem_to_reg,
           reg_rd, reg_wr, alu_src_b, alu_op, retired, err, state_o
  );
endinterface

`default_nettype wire

// File: rtl/mc_ctrl_fsm_wait_timer.sv
// ----------------------------------------------------------------------------
// mc_wait_timer : saturating memory-wait counter with timeout compare
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mc_wait_timer #(
  parameter int TIMEOUT_CYC = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic cnt_i,
  output logic timeout_o
);

  localparam int CW = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);

  generate
    if (TIMEOUT_CYC != 0) begin : g_on
      localparam logic [CW-1:0] c_LAST = CW'(TIMEOUT_CYC - 1);
      logic [CW-1:0] cnt_q;

      always_ff @(posedge clk) begin
        if (reset || clr_i) begin
          cnt_q <= '0;
        end else if (cnt_i && (cnt_q != {CW{1'b1}})) begin
          cnt_q <= cnt_q + CW'(1);
        end
      end

      // Fires in the wait cycle that brings the count up to TIMEOUT_CYC.
      assign timeout_o = cnt_i && (cnt_q >= c_LAST);
    end else begin : g_off
      logic w_unused_ok;
      assign w_unused_ok = ^{clk, reset, clr_i, cnt_i};
      assign timeout_o   = 1'b0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/mc_ctrl_fsm.sv
// ----------------------------------------------------------------------------
// mc_ctrl_fsm : multicycle MIPS32 control FSM; MC_CTRL_ILLEGAL_TRAP_EN traps bad opcodes
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int OPC_W       = 6,
  parameter int ALUOP_W     = 2,
  parameter int TIMEOUT_CYC = 15,
  parameter int CNT_W       = 32
) (
  input  logic          clk,
  input  logic          reset,
  mc_ctrl_fsm_if.master bus
);

  localparam logic [OPC_W-1:0]   c_R     = OPC_W'(c_OP_R);
  localparam logic [OPC_W-1:0]   c_J     = OPC_W'(c_OP_J);
  localparam logic [OPC_W-1:0]   c_BEQ   = OPC_W'(c_OP_BEQ);
  localparam logic [OPC_W-1:0]   c_ADDIU = OPC_W'(c_OP_ADDIU);
  localparam logic [OPC_W-1:0]   c_LW    = OPC_W'(c_OP_LW);
  localparam logic [OPC_W-1:0]   c_SW    = OPC_W'(c_OP_SW);
  localparam logic [ALUOP_W-1:0] c_AOP_ADD = ALUOP_W'(c_ALU_ADD);
  localparam logic [ALUOP_W-1:0] c_AOP_SUB = ALUOP_W'(c_ALU_SUB);
  localparam logic [ALUOP_W-1:0] c_AOP_FN  = ALUOP_W'(c_ALU_FUNCT);

  state_e             state_q, state_d;
  logic [OPC_W-1:0]   op_q, op_d;
  logic [CNT_W-1:0]   retired_q;
  logic               err_q;

  logic               w_pc_ld, w_iord, w_mem_rd, w_mem_wr, w_ir_wr;
  logic               w_reg_dst, w_mem_to_reg, w_reg_rd, w_reg_wr;
  logic [1:0]         w_pc_sel, w_alu_src_b;
  logic [ALUOP_W-1:0] w_alu_op;
  logic               w_in_mem, w_clr, w_cnt, w_timeout, w_legal;

  // The wait count restarts whenever we are outside a memory state or an access completes.
  assign w_in_mem = (state_q == S_FETCH) || (state_q == S_MEM);
  assign w_clr    = !w_in_mem || bus.mem_ready;
  assign w_cnt    = w_in_mem && !bus.mem_ready;

  mc_wait_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wait_timer (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (w_clr),
    .cnt_i     (w_cnt),
    .timeout_o (w_timeout)
  );

  assign w_legal = (bus.opcode == c_R)  || (bus.opcode == c_ADDIU) ||
                   (bus.opcode == c_LW) || (bus.opcode == c_SW)    ||
                   (bus.opcode == c_BEQ);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      retired_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      if (w_pc_ld) begin
        retired_q <= retired_q + CNT_W'(1);
      end
      if (state_d == S_ERR) begin
        err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    w_pc_ld      = 1'b0;
    w_pc_sel     = c_PCS_SEQ;
    w_iord       = 1'b0;
    w_mem_rd     = 1'b0;
    w_mem_wr     = 1'b0;
    w_ir_wr      = 1'b0;
    w_reg_dst    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_reg_rd     = 1'b0;
    w_reg_wr     = 1'b0;
    w_alu_src_b  = 2'd0;
    w_alu_op     = c_AOP_ADD;

    // Outputs stay quiet during reset so an aborted instruction never commits.
    if (!reset) begin
      unique case (state_q)
        S_IDLE: state_d = S_FETCH;

        S_FETCH: begin
          w_mem_rd = 1'b1;
          if (bus.mem_ready) begin
            w_ir_wr = 1'b1;
            state_d = S_DECODE;
          end else if (w_timeout) begin
            state_d = S_ERR;
          end
        end

        S_DECODE: begin
          w_reg_rd = 1'b1;
          op_d     = bus.opcode;
          if (bus.opcode == c_J) begin
            w_pc_ld  = 1'b1;
            w_pc_sel = c_PCS_JUMP;
            state_d  = S_FETCH;
          end else if (w_legal) begin
            state_d = S_EXEC;
          end else begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            state_d = S_ERR;
`else
            w_pc_ld  = 1'b1;
            w_pc_sel = c_PCS_SEQ;
            state_d  = S_FETCH;
`endif
          end
        end

        S_EXEC: begin
          if (op_q == c_R) begin
            w_alu_op = c_AOP_FN;
            state_d  = S_WB;
          end else if ((op_q == c_ADDIU) || (op_q == c_LW) || (op_q == c_SW)) begin
            w_alu_op    = c_AOP_ADD;
            w_alu_src_b = 2'd1;
            state_d     = (op_q == c_ADDIU) ? S_WB : S_MEM;
          end else if (op_q == c_BEQ) begin
            w_alu_op = c_AOP_SUB;
            w_pc_ld  = 1'b1;
            w_pc_sel = bus.alu_zero ? c_PCS_BRANCH : c_PCS_SEQ;
            state_d  = S_FETCH;
          end else begin
            state_d = S_ERR;
          end
        end

        S_MEM: begin
          w_iord   = 1'b1;
          w_mem_rd = (op_q == c_LW);
          w_mem_wr = (op_q != c_LW);
          if (bus.mem_ready) begin
            if (op_q == c_LW) begin
              state_d = S_MEMWB;
            end else begin
              w_pc_ld = 1'b1;
              state_d = S_FETCH;
            end
          end else if (w_timeout) begin
            state_d = S_ERR;
          end
        end

        S_WB: begin
          w_reg_wr  = 1'b1;
          w_reg_dst = (op_q == c_R);
          w_pc_ld   = 1'b1;
          state_d   = S_FETCH;
        end

        S_MEMWB: begin
          w_reg_wr     = 1'b1;
          w_mem_to_reg = 1'b1;
          w_pc_ld      = 1'b1;
          state_d      = S_FETCH;
        end

        S_ERR: state_d = S_ERR;

        default: state_d = S_ERR;
      endcase
    end
  end

  assign bus.pc_ld      = w_pc_ld;
  assign bus.pc_sel     = w_pc_sel;
  assign bus.iord       = w_iord;
  assign bus.mem_rd     = w_mem_rd;
  assign bus.mem_wr     = w_mem_wr;
  assign bus.ir_wr      = w_ir_wr;
  assign bus.reg_dst    = w_reg_dst;
  assign bus.mem_to_reg = w_mem_to_reg;
  assign bus.reg_rd     = w_reg_rd;
  assign bus.reg_wr     = w_reg_wr;
  assign bus.alu_src_b  = w_alu_src_b;
  assign bus.alu_op     = w_alu_op;
  assign bus.retired    = retired_q;
  assign bus.err        = err_q;
  assign bus.state_o    = state_q;

endmodule

`default_nettype wire

// File: tb/tb_mc_ctrl_fsm.sv
// ----------------------------------------------------------------------------
// tb_mc_ctrl_fsm : directed self-checking bench for mc_ctrl_fsm (TIMEOUT_CYC = 4)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mc_ctrl_fsm;

  localparam logic [3:0] ST_IDLE = 4'd0, ST_FETCH = 4'd1, ST_DECODE = 4'd2, ST_EXEC = 4'd3;
  localparam logic [3:0] ST_MEM = 4'd4, ST_WB = 4'd5, ST_MEMWB = 4'd6, ST_ERR = 4'd7;

  // Packed control view: {pc_ld, pc_sel[1:0], iord, mem_rd, mem_wr, ir_wr, reg_dst,
  //                       mem_to_reg, reg_rd, reg_wr, alu_src_b[1:0], alu_op[1:0], err}
  localparam logic [15:0] B_PCLD = 16'h8000, B_PCBR = 16'h4000, B_PCJ  = 16'h2000;
  localparam logic [15:0] B_IORD = 16'h1000, B_MRD  = 16'h0800, B_MWR  = 16'h0400;
  localparam logic [15:0] B_IRWR = 16'h0200, B_RDST = 16'h0100, B_M2R  = 16'h0080;
  localparam logic [15:0] B_RRD  = 16'h0040, B_RWR  = 16'h0020, B_IMM  = 16'h0008;
  localparam logic [15:0] B_AFN  = 16'h0004, B_ASUB = 16'h0002, B_ERR  = 16'h0001;

  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ADDIU = 6'h09, OP_LW = 6'h23, OP_SW = 6'h2B, OP_BAD = 6'h3F;

  logic clk;
  logic reset;
  int   n_pass  = 0;
  int   n_total = 0;
  int   n_fail  = 0;

  mc_ctrl_fsm_if #(.OPC_W(6), .ALUOP_W(2), .CNT_W(32)) bus ();

  mc_ctrl_fsm #(
    .OPC_W       (6),
    .ALUOP_W     (2),
    .TIMEOUT_CYC (4),
    .CNT_W       (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ctl_now();
    return {bus.pc_ld, bus.pc_sel, bus.iord, bus.mem_rd, bus.mem_wr, bus.ir_wr,
            bus.reg_dst, bus.mem_to_reg, bus.reg_rd, bus.reg_wr, bus.alu_src_b,
            bus.alu_op, bus.err};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Check one cycle's state and controls with the current inputs, then advance past the edge.
  task automatic cyc(input string tag, input logic [3:0] st, input logic [15:0] ctl);
    #1;
    chk({tag, ".state"}, 32'(bus.state_o), 32'(st));
    chk({tag, ".ctl"}, 32'(ctl_now()), 32'(ctl));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    bus.opcode    = OP_R;
    bus.alu_zero  = 1'b0;
    bus.mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.ctl", 32'(ctl_now()), 32'h0);
    chk("rst.state", 32'(bus.state_o), 32'(ST_IDLE));
    chk("rst.retired", bus.retired, 32'd0);
    chk("rst.err", 32'(bus.err), 32'd0);
    reset = 1'b0;
    cyc("idle", ST_IDLE, 16'h0);

    // R-type, memory always ready
    cyc("r.f", ST_FETCH, B_MRD | B_IRWR);
    cyc("r.d", ST_DECODE, B_RRD);
    cyc("r.e", ST_EXEC, B_AFN);
    cyc("r.wb", ST_WB, B_RWR | B_RDST | B_PCLD);
    chk("r.retired", bus.retired, 32'd1);

    // LW with three not-ready cycles in MEM: 8 cycles total
    bus.opcode = OP_LW;
    cyc("lw.f", ST_FETCH, B_MRD | B_IRWR);
    cyc("lw.d", ST_DECODE, B_RRD);
    cyc("lw.e", ST_EXEC, B_IMM);
    bus.mem_ready = 1'b0;
    cyc("lw.m0", ST_MEM, B_IORD | B_MRD);
    cyc("lw.m1", ST_MEM, B_IORD | B_MRD);
    cyc("lw.m2", ST_MEM, B_IORD | B_MRD);
    bus.mem_ready = 1'b1;
    cyc("lw.m3", ST_MEM, B_IORD | B_MRD);
    cyc("lw.mwb", ST_MEMWB, B_RWR | B_M2R | B_PCLD);
    chk("lw.retired", bus.retired, 32'd2);

    // SW retires from MEM in the ready cycle
    bus.opcode = OP_SW;
    cyc("sw.f", ST_FETCH, B_MRD | B_IRWR);
    cyc("sw.d", ST_DECODE, B_RRD);
    cyc("sw.e", ST_EXEC, B_IMM);
    cyc("sw.m", ST_MEM, B_IORD | B_MWR | B_PCLD);
    chk("sw.retired", bus.retired, 32'd3);

    // BEQ taken then not taken
    bus.opcode   = OP_BEQ;
    bus.alu_zero = 1'b1;
    cyc("beq1.f", ST_FETCH, B_MRD | B_IRWR);
    cyc("beq1.d", ST_DECODE, B_RRD);
    cyc("beq1.e", ST_EXEC, B_ASUB | B_PCLD | B_PCBR);
    bus.alu_zero = 1'b0;
    cyc("beq0.f", ST_FETCH, B_MRD | B_IRWR);
    cyc("beq0.d", ST_DECODE, B_RRD);
    cyc("beq0.e", ST_EXEC, B_ASUB | B_PCLD);
    chk("beq.retired", bus.retired, 32'd5);

    // ADDIU writes rt
    bus.opcode = OP_ADDIU;
    cyc("addiu.f", ST_FETCH, B_MRD | B_IRWR);
    cyc("addiu.d", ST_DECODE, B_RRD);
    cyc("addiu.e", ST_EXEC, B_IMM);
    cyc("addiu.wb", ST_WB, B_RWR | B_PCLD);

    // J completes in DECODE
    bus.opcode = OP_J;
    cyc("j.f", ST_FETCH, B_MRD | B_IRWR);
    cyc("j.d", ST_DECODE, B_RRD | B_PCLD | B_PCJ);
    chk("j.retired", bus.retired, 32'd7);

    // Three fetch wait cycles stay below the timeout, then an illegal opcode
    bus.opcode    = OP_BAD;
    bus.mem_ready = 1'b0;
    cyc("bad.w0", ST_FETCH, B_MRD);
    cyc("bad.w1", ST_FETCH, B_MRD);
    cyc("bad.w2", ST_FETCH, B_MRD);
    bus.mem_ready = 1'b1;
    cyc("bad.f", ST_FETCH, B_MRD | B_IRWR);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    cyc("bad.d", ST_DECODE, B_RRD);
    cyc("bad.err", ST_ERR, B_ERR);
    chk("bad.retired", bus.retired, 32'd7);
`else
    cyc("bad.d", ST_DECODE, B_RRD | B_PCLD);
    chk("bad.retired", bus.retired, 32'd8);
    chk("bad.err", 32'(bus.err), 32'd0);
`endif

    // Reset, then let FETCH time out after four wait cycles
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst2.retired", bus.retired, 32'd0);
    chk("rst2.err", 32'(bus.err), 32'd0);
    cyc("rst2.idle", ST_IDLE, 16'h0);
    bus.mem_ready = 1'b0;
    cyc("to.w0", ST_FETCH, B_MRD);
    cyc("to.w1", ST_FETCH, B_MRD);
    cyc("to.w2", ST_FETCH, B_MRD);
    cyc("to.w3", ST_FETCH, B_MRD);
    cyc("to.err0", ST_ERR, B_ERR);
    bus.mem_ready = 1'b1;
    cyc("to.err1", ST_ERR, B_ERR);
    cyc("to.err2", ST_ERR, B_ERR);

    // Reset leaves ERR; then abort an R instruction in WB
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst3.err", 32'(bus.err), 32'd0);
    bus.opcode = OP_R;
    cyc("ab.idle", ST_IDLE, 16'h0);
    cyc("ab.f", ST_FETCH, B_MRD | B_IRWR);
    cyc("ab.d", ST_DECODE, B_RRD);
    cyc("ab.e", ST_EXEC, B_AFN);
    reset = 1'b1;
    cyc("ab.wb", ST_WB, 16'h0);
    reset = 1'b0;
    chk("ab.state", 32'(bus.state_o), 32'(ST_IDLE));
    chk("ab.retired", bus.retired, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
